// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg -- shared definitions for the CPU run/step/halt controller.
// Holds the FSM state encoding, default debounce and soft-reset lengths,
// and the IO / debug bus widths used by run_ctrl and btn_debounce.
package run_ctrl_pkg;

    // IO bus (PC / breakpoint) and debug bus (step counter) widths
    localparam int IO_W   = 32;
    localparam int DBG_W  = 16;

    // Counter widths for the debounce and soft-reset timers
    localparam int DEB_W  = 20;
    localparam int RSTC_W = 8;

    localparam logic [DEB_W-1:0]  DEB_CYCLES_DEF = 20'd1000000;
    localparam logic [RSTC_W-1:0] RST_CYCLES_DEF = 8'd16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_HALT = 3'd3,
        ST_RSTP = 3'd4
    } run_state_e;

    // States in which the CPU pipeline is allowed to advance
    function automatic logic is_advance(input run_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- single-button debouncer with press detection.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   raw      : button level, already synchronous to clk
//   level    : accepted (debounced) level
//   press    : one-cycle pulse when the accepted level rises
// The accepted level follows raw only after raw has differed from it for
// DEB_CYCLES consecutive cycles; any return to the accepted level restarts
// the count.
module btn_debounce
    import run_ctrl_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    // A zero length behaves like a one-cycle filter
    localparam logic [DEB_W-1:0] LAST_CNT =
        (DEB_CYCLES == '0) ? '0 : DEB_CYCLES - DEB_W'(1);

    logic [DEB_W-1:0] cnt_reg;
    logic             level_reg;
    logic             press_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (raw != level_reg) begin
                if (cnt_reg == LAST_CNT) begin
                    level_reg <= raw;
                    cnt_reg   <= '0;
                    press_reg <= raw;   // rising edges only
                end else begin
                    cnt_reg <= cnt_reg + DEB_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl -- run / single-step / halt / soft-reset controller for a CPU.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   butc, butd, butr, butl   : raw run, step, halt, soft-reset buttons
//   bp_en, bp_addr, if_pc    : breakpoint enable / address, fetch PC
//   cpu_stop                 : CPU self-halt indication
//   pdu_run                  : CPU advance enable
//   pdu_rstn                 : CPU soft reset, active-low
//   pdu_breakpoint           : bp_addr when enabled, else all ones
//   state, step_cnt, stop_led: status
// Outputs pdu_run / pdu_rstn / stop_led are registered from the next state
// so they line up with the state register.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter logic [DEB_W-1:0]  DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic [RSTC_W-1:0] RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             butc,
    input  logic             butd,
    input  logic             butr,
    input  logic             butl,
    input  logic             bp_en,
    input  logic [IO_W-1:0]  bp_addr,
    input  logic [IO_W-1:0]  if_pc,
    input  logic             cpu_stop,
    output logic             pdu_run,
    output logic             pdu_rstn,
    output logic [IO_W-1:0]  pdu_breakpoint,
    output logic [2:0]       state,
    output logic [DBG_W-1:0] step_cnt,
    output logic             stop_led
);

    // Button index: 0 run, 1 step, 2 halt, 3 soft reset
    logic [3:0] raw_vec;
    logic [3:0] press_vec;
    logic [3:0] btn_level_unused;

    assign raw_vec = {butl, butr, butd, butc};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_vec[gi]),
                .level (btn_level_unused[gi]),
                .press (press_vec[gi])
            );
        end
    endgenerate

    logic run_press, step_press, halt_press, reset_press;
    assign run_press   = press_vec[0];
    assign step_press  = press_vec[1];
    assign halt_press  = press_vec[2];
    assign reset_press = press_vec[3];

    run_state_e        state_reg, state_next;
    logic [RSTC_W-1:0] rst_cnt_reg, rst_cnt_next;
    logic [DBG_W-1:0]  step_cnt_reg, step_cnt_next;
    logic              armed_reg, armed_next;
    logic              pdu_run_reg, pdu_rstn_reg, stop_led_reg;
    logic              bp_match, entering;

    assign bp_match = bp_en && armed_reg && (if_pc == bp_addr);

    always_comb begin
        state_next    = state_reg;
        rst_cnt_next  = rst_cnt_reg;
        step_cnt_next = step_cnt_reg;
        // Reset press outranks everything, but cannot retrigger an active pulse
        if (reset_press && (state_reg != ST_RSTP)) begin
            state_next   = ST_RSTP;
            rst_cnt_next = RST_CYCLES;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    // A halt press here does nothing but still swallows
                    // any lower-priority step/run press of the same cycle
                    if (!halt_press) begin
                        if (step_press)
                            state_next = ST_STEP;
                        else if (run_press)
                            state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_press || cpu_stop || bp_match)
                        state_next = ST_HALT;
                end
                ST_STEP: begin
                    state_next    = ST_HALT;
                    step_cnt_next = step_cnt_reg + DBG_W'(1);
                end
                ST_RSTP: begin
                    if (rst_cnt_reg <= RSTC_W'(1))
                        state_next = ST_IDLE;
                    else
                        rst_cnt_next = rst_cnt_reg - RSTC_W'(1);
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Disarm on resume so a halt at the breakpoint PC is not re-taken until
    // the PC has moved away at least once.
    assign entering   = ((state_next == ST_RUN) && (state_reg != ST_RUN)) ||
                        (state_next == ST_STEP);
    assign armed_next = (if_pc != bp_addr) || (armed_reg && !entering);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rst_cnt_reg  <= '0;
            step_cnt_reg <= '0;
            armed_reg    <= 1'b0;
            pdu_run_reg  <= 1'b0;
            pdu_rstn_reg <= 1'b1;
            stop_led_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rst_cnt_reg  <= rst_cnt_next;
            step_cnt_reg <= step_cnt_next;
            armed_reg    <= armed_next;
            pdu_run_reg  <= is_advance(state_next);
            pdu_rstn_reg <= (state_next != ST_RSTP);
            stop_led_reg <= (state_next == ST_HALT);
        end
    end

    assign pdu_run        = pdu_run_reg;
    assign pdu_rstn       = pdu_rstn_reg;
    assign stop_led       = stop_led_reg;
    assign state          = state_reg;
    assign step_cnt       = step_cnt_reg;
    assign pdu_breakpoint = bp_en ? bp_addr : {IO_W{1'b1}};

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- self-checking bench for run_ctrl (DEB_CYCLES=4, RST_CYCLES=3).
// Each vector drives inputs at a falling edge, holds them for n cycles and
// then compares the outputs against the expectation queued when it was driven.
module tb_run_ctrl;

    localparam logic [2:0] S_I  = 3'd0;
    localparam logic [2:0] S_RU = 3'd1;
    localparam logic [2:0] S_ST = 3'd2;
    localparam logic [2:0] S_H  = 3'd3;
    localparam logic [2:0] S_RP = 3'd4;

    localparam logic [3:0] B_C = 4'b0001;
    localparam logic [3:0] B_D = 4'b0010;
    localparam logic [3:0] B_R = 4'b0100;
    localparam logic [3:0] B_L = 4'b1000;

    localparam logic [31:0] BP = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst, butc, butd, butr, butl, bp_en, cpu_stop;
    logic [31:0] bp_addr, if_pc, pdu_breakpoint;
    logic        pdu_run, pdu_rstn, stop_led;
    logic [2:0]  state;
    logic [15:0] step_cnt;

    always #5 clk = ~clk;

    run_ctrl #(.DEB_CYCLES(20'd4), .RST_CYCLES(8'd3)) dut (
        .clk            (clk),
        .rst            (rst),
        .butc           (butc),
        .butd           (butd),
        .butr           (butr),
        .butl           (butl),
        .bp_en          (bp_en),
        .bp_addr        (bp_addr),
        .if_pc          (if_pc),
        .cpu_stop       (cpu_stop),
        .pdu_run        (pdu_run),
        .pdu_rstn       (pdu_rstn),
        .pdu_breakpoint (pdu_breakpoint),
        .state          (state),
        .step_cnt       (step_cnt),
        .stop_led       (stop_led)
    );

    typedef struct {
        string       name;
        logic        r;
        logic [3:0]  btn;
        logic        stop;
        logic        en;
        logic [31:0] pc;
        int          n;
        logic [2:0]  st;
        logic        run;
        logic        rstn;
        logic        led;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        run;
        logic        rstn;
        logic        led;
        logic [15:0] cnt;
        logic [31:0] bp;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string nm, input logic r, input logic [3:0] b,
                                input logic s, input logic e, input logic [31:0] p,
                                input int n, input logic [2:0] st, input logic run,
                                input logic rstn, input logic led, input logic [15:0] cnt);
        vec_t v;
        v = '{nm, r, b, s, e, p, n, st, run, rstn, led, cnt};
        return v;
    endfunction

    task automatic add(input string nm, input logic r, input logic [3:0] b,
                       input logic s, input logic e, input logic [31:0] p,
                       input int n, input logic [2:0] st, input logic run,
                       input logic rstn, input logic led, input logic [15:0] cnt);
        vecs.push_back(mk(nm, r, b, s, e, p, n, st, run, rstn, led, cnt));
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        rst      = v.r;
        butc     = v.btn[0];
        butd     = v.btn[1];
        butr     = v.btn[2];
        butl     = v.btn[3];
        cpu_stop = v.stop;
        bp_en    = v.en;
        if_pc    = v.pc;
        e = '{v.name, v.st, v.run, v.rstn, v.led, v.cnt, v.en ? BP : 32'hFFFF_FFFF};
        exp_q.push_back(e);
        repeat (v.n) @(negedge clk);
        e = exp_q.pop_front();
        check({e.name, ".state"},    32'(state),    32'(e.st));
        check({e.name, ".pdu_run"},  32'(pdu_run),  32'(e.run));
        check({e.name, ".pdu_rstn"}, 32'(pdu_rstn), 32'(e.rstn));
        check({e.name, ".stop_led"}, 32'(stop_led), 32'(e.led));
        check({e.name, ".step_cnt"}, 32'(step_cnt), 32'(e.cnt));
        check({e.name, ".bp_out"},   pdu_breakpoint, e.bp);
        $display("%-10s state=%0d run=%b rstn=%b led=%b cnt=%04h bp=%08h",
                 e.name, state, pdu_run, pdu_rstn, stop_led, step_cnt, pdu_breakpoint);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; butc = 1'b0; butd = 1'b0; butr = 1'b0; butl = 1'b0;
        bp_en = 1'b0; cpu_stop = 1'b0; bp_addr = BP; if_pc = 32'h0;

        //   name         r  btn      stp en pc     n  state run rstn led cnt
        add("reset",      1, 4'b0,    0, 0, 32'h0,  2, S_I,  0, 1, 0, 16'd0);
        add("rst_rel",    0, 4'b0,    0, 0, 32'h0,  1, S_I,  0, 1, 0, 16'd0);
        add("bounce3",    0, B_C,     0, 0, 32'h0,  3, S_I,  0, 1, 0, 16'd0);
        add("bounce_lo",  0, 4'b0,    0, 0, 32'h0,  6, S_I,  0, 1, 0, 16'd0);
        add("run_wait",   0, B_C,     0, 0, 32'h0,  4, S_I,  0, 1, 0, 16'd0);
        add("run_enter",  0, B_C,     0, 0, 32'h0,  1, S_RU, 1, 1, 0, 16'd0);
        add("run_hold",   0, B_C,     0, 0, 32'h0,  1, S_RU, 1, 1, 0, 16'd0);
        add("run_rel",    0, 4'b0,    0, 1, 32'h0,  5, S_RU, 1, 1, 0, 16'd0);
        add("bp_hit",     0, 4'b0,    0, 1, 32'h40, 1, S_H,  0, 1, 1, 16'd0);
        add("resume",     0, B_C,     0, 1, 32'h40, 5, S_RU, 1, 1, 0, 16'd0);
        add("no_rehit",   0, B_C,     0, 1, 32'h40, 3, S_RU, 1, 1, 0, 16'd0);
        add("pc44",       0, 4'b0,    0, 1, 32'h44, 5, S_RU, 1, 1, 0, 16'd0);
        add("bp_hit2",    0, 4'b0,    0, 1, 32'h40, 1, S_H,  0, 1, 1, 16'd0);
        add("run2",       0, B_C,     0, 0, 32'h0,  5, S_RU, 1, 1, 0, 16'd0);
        add("run2_rel",   0, 4'b0,    0, 0, 32'h0,  4, S_RU, 1, 1, 0, 16'd0);
        add("run_noop",   0, B_C,     0, 0, 32'h0,  5, S_RU, 1, 1, 0, 16'd0);
        add("noop_rel",   0, 4'b0,    0, 0, 32'h0,  4, S_RU, 1, 1, 0, 16'd0);
        add("cpu_stop",   0, 4'b0,    1, 0, 32'h0,  1, S_H,  0, 1, 1, 16'd0);
        add("halt_noop",  0, B_R,     0, 0, 32'h0,  5, S_H,  0, 1, 1, 16'd0);
        add("halt_rel",   0, 4'b0,    0, 0, 32'h0,  4, S_H,  0, 1, 1, 16'd0);
        add("run3",       0, B_C,     0, 0, 32'h0,  5, S_RU, 1, 1, 0, 16'd0);
        add("run3_rel",   0, 4'b0,    0, 0, 32'h0,  4, S_RU, 1, 1, 0, 16'd0);
        add("lr_wait",    0, B_L|B_R, 0, 0, 32'h0,  4, S_RU, 1, 1, 0, 16'd0);
        add("rstp1",      0, B_L|B_R, 0, 0, 32'h0,  1, S_RP, 0, 0, 0, 16'd0);
        add("rstp2",      0, B_L|B_R, 0, 0, 32'h0,  1, S_RP, 0, 0, 0, 16'd0);
        add("rstp3",      0, B_L|B_R, 0, 0, 32'h0,  1, S_RP, 0, 0, 0, 16'd0);
        add("rstp_exit",  0, B_L|B_R, 0, 0, 32'h0,  1, S_I,  0, 1, 0, 16'd0);
        add("lr_rel",     0, 4'b0,    0, 0, 32'h0,  4, S_I,  0, 1, 0, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            add("step_wait",  0, B_D,  0, 0, 32'h0, 4, (k == 1) ? S_I : S_H, 0, 1, k > 1, 16'(k - 1));
            add("step_pulse", 0, B_D,  0, 0, 32'h0, 1, S_ST, 1, 1, 0, 16'(k - 1));
            add("step_done",  0, 4'b0, 0, 0, 32'h0, 1, S_H,  0, 1, 1, 16'(k));
            add("step_rel",   0, 4'b0, 0, 0, 32'h0, 3, S_H,  0, 1, 1, 16'(k));
        end
        add("cd_wait",    0, B_C|B_D, 0, 0, 32'h0,  4, S_H,  0, 1, 1, 16'd3);
        add("cd_step",    0, B_C|B_D, 0, 0, 32'h0,  1, S_ST, 1, 1, 0, 16'd3);
        add("cd_done",    0, 4'b0,    0, 0, 32'h0,  1, S_H,  0, 1, 1, 16'd4);
        add("cd_rel",     0, 4'b0,    0, 0, 32'h0,  3, S_H,  0, 1, 1, 16'd4);
        add("rd_noop",    0, B_R|B_D, 0, 0, 32'h0,  5, S_H,  0, 1, 1, 16'd4);
        add("rd_rel",     0, 4'b0,    0, 0, 32'h0,  4, S_H,  0, 1, 1, 16'd4);

        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i]);

        // Step counter wrap: preload all ones while idling in HALT
        force dut.step_cnt_reg = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.step_cnt_reg;
        check("preload.step_cnt", 32'(step_cnt), 32'h0000_FFFF);
        apply(mk("wrap_step", 0, B_D,  0, 0, 32'h0, 5, S_ST, 1, 1, 0, 16'hFFFF));
        apply(mk("wrap_done", 0, 4'b0, 0, 0, 32'h0, 1, S_H,  0, 1, 1, 16'h0000));
        apply(mk("wrap_rel",  0, 4'b0, 0, 0, 32'h0, 3, S_H,  0, 1, 1, 16'h0000));

        // Hard reset in the middle of RSTP, RUN and STEP
        apply(mk("rstp_in",   0, B_L,  0, 0, 32'h0, 5, S_RP, 0, 0, 0, 16'h0));
        apply(mk("rst_rstp",  1, 4'b0, 0, 0, 32'h0, 1, S_I,  0, 1, 0, 16'h0));
        apply(mk("after_rp",  0, 4'b0, 0, 0, 32'h0, 6, S_I,  0, 1, 0, 16'h0));
        apply(mk("run_in",    0, B_C,  0, 0, 32'h0, 5, S_RU, 1, 1, 0, 16'h0));
        apply(mk("rst_run",   1, 4'b0, 0, 0, 32'h0, 1, S_I,  0, 1, 0, 16'h0));
        apply(mk("after_run", 0, 4'b0, 0, 0, 32'h0, 6, S_I,  0, 1, 0, 16'h0));
        apply(mk("step_in",   0, B_D,  0, 0, 32'h0, 5, S_ST, 1, 1, 0, 16'h0));
        apply(mk("rst_step",  1, 4'b0, 0, 0, 32'h0, 1, S_I,  0, 1, 0, 16'h0));
        apply(mk("after_st",  0, 4'b0, 0, 0, 32'h0, 6, S_I,  0, 1, 0, 16'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
